// File: rtl/vedic_div16by8.sv
// rtl/vedic_div16by8.sv - restoring divider, one quotient bit per clock, valid/ready in and out
module vedic_div16by8 #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          busy
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;
  logic [CW-1:0] cnt;
  logic [VW:0]   p;
  logic [VW:0]   t, t_sub;
  logic          q_bit;

  // dvd_q doubles as the quotient shift register: dividend bits leave at
  // the top while quotient bits enter at the bottom.
  assign t     = {p[VW-1:0], dvd_q[DW-1]};
  assign t_sub = t - {1'b0, dvs_q};
  assign q_bit = (t >= {1'b0, dvs_q});

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (dvs_q == '0 || cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      cnt         <= '0;
      p           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            cnt   <= CW'(DW - 1);
            p     <= '0;
          end
        end
        RUN: begin
          // Zero divisor skips the iterations and finishes in a single cycle.
          if (dvs_q == '0) begin
            quotient    <= '1;
            remainder   <= dvd_q[VW-1:0];
            div_by_zero <= 1'b1;
          end else begin
            p     <= q_bit ? t_sub : t;
            dvd_q <= {dvd_q[DW-2:0], q_bit};
            cnt   <= cnt - 1'b1;
            if (cnt == '0) begin
              quotient    <= {dvd_q[DW-2:0], q_bit};
              remainder   <= q_bit ? t_sub[VW-1:0] : t[VW-1:0];
              div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_div16by8.sv
// tb/tb_vedic_div16by8.sv - directed self-checking bench for vedic_div16by8
module tb_vedic_div16by8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vedic_div16by8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold,
                        output logic [15:0] q, output logic [7:0] r, output logic z,
                        output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    #12;
    checks++;
    if ({in_ready, out_valid, busy, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b ov=%b busy=%b q=%0d r=%0d z=%b want 1 0 0 0 0 0",
               in_ready, out_valid, busy, quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [15:0] q; logic [7:0] r; logic z; int lat;
    run_op(16'd50625, 8'd225, 0, q, r, z, lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL basic_latency got %0d want 16", lat);
    end
    checks++;
    if ({q, r, z} !== {16'd225, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL basic_result got q=%0d r=%0d z=%b want 225 0 0", q, r, z);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_release got rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_vectors;
    logic [15:0] va [3] = '{16'd1000, 16'd65535, 16'd200};
    logic [7:0]  vb [3] = '{8'd7, 8'd255, 8'd201};
    logic [15:0] eq [3] = '{16'd142, 16'd257, 16'd0};
    logic [7:0]  er [3] = '{8'd6, 8'd0, 8'd200};
    logic [15:0] q; logic [7:0] r; logic z; int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 0, q, r, z, lat);
      checks++;
      if ({q, r, z, lat} !== {eq[i], er[i], 1'b0, 32'd16}) begin
        failures++;
        $display("FAIL vector_%0d got q=%0d r=%0d z=%b lat=%0d want %0d %0d 0 16",
                 i, q, r, z, lat, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [15:0] q; logic [7:0] r; logic z; int lat;
    run_op(16'd5, 8'd0, 0, q, r, z, lat);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL divzero_latency got %0d want 1", lat);
    end
    checks++;
    if ({q, r, z} !== {16'hFFFF, 8'd5, 1'b1}) begin
      failures++;
      $display("FAIL divzero_result got q=%h r=%0d z=%b want ffff 5 1", q, r, z);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    dividend = 16'd1000; divisor = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    dividend = 16'd9; divisor = 8'd3;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, quotient, remainder} !== {1'b1, 1'b0, 16'd142, 8'd6}) begin
        failures++;
        $display("FAIL backpressure_hold_%0d got ov=%b rdy=%b q=%0d r=%0d want 1 0 142 6",
                 i, out_valid, in_ready, quotient, remainder);
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_rdy_at_handshake got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release got rdy=%b ov=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] q; logic [7:0] r; logic z; int lat; int spurious;
    dividend = 16'd1000; divisor = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_state got rdy=%b ov=%b busy=%b q=%0d r=%0d z=%b want 1 0 0 0 0 0",
               in_ready, out_valid, busy, quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    spurious = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid || busy) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      failures++;
      $display("FAIL reset_mid_spurious got %0d active cycles want 0", spurious);
    end
    run_op(16'd1000, 8'd7, 0, q, r, z, lat);
    checks++;
    if ({q, r, z, lat} !== {16'd142, 8'd6, 1'b0, 32'd16}) begin
      failures++;
      $display("FAIL reset_mid_next got q=%0d r=%0d z=%b lat=%0d want 142 6 0 16", q, r, z, lat);
    end
  endtask

  task automatic test_round_trip;
    logic [7:0] bl [12] = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd15, 8'd64, 8'd127, 8'd128, 8'd129, 8'd200, 8'd254, 8'd255};
    logic [15:0] q; logic [7:0] r; logic z; int lat;
    logic [15:0] m;
    for (int ai = 0; ai <= 17; ai++) begin
      for (int bi = 0; bi < 12; bi++) begin
        logic [7:0] a;
        a = (ai == 17) ? 8'd255 : 8'(ai * 15);
        m = 16'(a) * 16'(bl[bi]);
        run_op(m, bl[bi], $urandom_range(0, 3), q, r, z, lat);
        checks++;
        if ({q, r, z, lat} !== {8'd0, a, 8'd0, 1'b0, 32'd16}) begin
          failures++;
          $display("FAIL round_trip m=%0d b=%0d got q=%0d r=%0d z=%b lat=%0d want %0d 0 0 16",
                   m, bl[bi], q, r, z, lat, a);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_vectors;
    test_div_zero;
    test_backpressure;
    test_reset_mid;
    test_round_trip;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
